dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (DMem) between NUM_PORTS requesters,
//  e.g. port 0 = core load/store unit, port 1 = debug/DMA loader.
//  Grants at most one access per cycle using round-robin.
//  Drives DMem's address, write-data and write-enable inputs.
//  Returns read data and write acks one cycle after acceptance, matching DMem's
//  registered-address timing. Misaligned accesses are rejected with an error.
// PARAMETERS
//  NUM_PORTS   2    number of requesters, legal range 2..4
//  PORT_W      $clog2(NUM_PORTS)   width of the port index (derived, not overridable)
//  CNT_W       16   width of per-port grant counters (saturating)
// PORTS
//  clk          in   1                 clock
//  rst          in   1                 reset, synchronous, active-low
//  reqValid     in   [NUM_PORTS]       request present
//  reqReady     out  [NUM_PORTS]       request accepted this cycle (one-hot or zero)
//  reqWrite     in   [NUM_PORTS]       1 = store, 0 = load
//  reqAddr      in   DataAddrPath x N  byte address
//  reqData      in   DataPath x N      store data
//  rspValid     out  [NUM_PORTS]       response for that port (one-hot or zero)
//  rspWrite     out  1                 response is a write ack
//  rspErr       out  1                 access rejected (misaligned)
//  rspData      out  DataPath          load data; 0 on write or error
//  memAddr      out  DataAddrPath      to DMem addr
//  memDataIn    out  DataPath          to DMem dataIn
//  memWrEnable  out  1                 to DMem wrEnable
//  memDataOut   in   DataPath          from DMem dataOut
//  grantCnt     out  CNT_W x N         accepted-request count per port
// BEHAVIOUR
//  - Reset (rst==0 at posedge): rrPtr=0, rsp regs cleared, grantCnt=0.
//    While rst==0: reqReady=0, memWrEnable=0, memAddr=0, memDataIn=0, rspValid=0.
//  - Arbitration (combinational, cycle N):
//    - Search starts at rrPtr and wraps modulo NUM_PORTS.
//    - The first port with reqValid set wins; reqReady[win]=1.
//    - A request is accepted when reqValid && reqReady. Requesters hold their
//      request until accepted.
//  - Accepted, aligned request (addr[DATA_MEM_OFFSET-1:0]==0):
//    - memAddr=reqAddr[win], memDataIn=reqData[win], memWrEnable=reqWrite[win].
//  - Accepted, misaligned request:
//    - Not forwarded to memory: memWrEnable=0.
//  - No request accepted: memWrEnable=0, memAddr=0, memDataIn=0.
//  - rrPtr update at posedge (only when a request was accepted):
//    - rrPtr <= win+1 mod NUM_PORTS.
//    - grantCnt[win]++, saturating at all-ones.
//  - Response, cycle N+1 (fixed latency 1, no backpressure):
//    - rspValid[win]=1, rspWrite=wr, rspErr=misaligned.
//    - rspData = memDataOut only for an aligned read; otherwise 0.
//  - One access per cycle; back-to-back acceptance is allowed every cycle.
//  - Read-after-write to the same address in cycles N, N+1 returns the new data.
//    DMem commits the write at the same edge that latches the read address, so
//    no forwarding is required.
//  - Reset asserted while a response is pending: the response is dropped.
//    rspValid stays 0 after reset release until a new acceptance.
//  - A single requester is never starved: worst-case wait is NUM_PORTS-1 grants.
// STRUCTURE
//  - Types package additions:
//    - typedef DmemPortIdx logic[PORT_W-1:0].
//    - struct DmemReq {write, addr, data}.
//    - struct DmemRsp {valid, write, err, data}.
//  - Reuse DATA_MEM_OFFSET, DataPath and DataAddrPath from the existing packages.
//  - Sub-module rr_arbiter (reqVec, ptr -> one-hot grant, winner index).
//    It is purely combinational and reusable for the register-file and IMem ports.
//  - Registered state in dmem_arbiter:
//    rrPtr, rsp regs (valid, port, write, err), grantCnt.
// TESTING (bench instantiates dmem_arbiter + DMem, NUM_PORTS=2)
//  1. Reset: hold rst=0 for 3 cycles with both reqValid=1.
//     -> reqReady=00, memWrEnable=0, rspValid=00, grantCnt=0.
//  2. P0 write addr 0x10 data 0xDEADBEEF (cycle N), then P0 read 0x10 (cycle N+1).
//     -> cycle N+1: rspValid=01, rspWrite=1.
//     -> cycle N+2: rspValid=01, rspData=0xDEADBEEF.
//  3. Both ports request reads continuously for 6 cycles from reset.
//     -> grants alternate 0,1,0,1,0,1; grantCnt={3,3}.
//  4. P1 read addr 0x13 (misaligned).
//     -> memWrEnable=0; next cycle rspValid=10, rspErr=1, rspData=0; grantCnt[1]++.
//  5. P1 write 0x20 accepted; rst=0 in the following cycle.
//     -> no rspValid after release; rrPtr=0.
//     -> a read of 0x20 returns either the old or the new value; the bench accepts
//        both but checks that no X appears.
//  6. Force grantCnt[0] to 0xFFFE, then 3 P0 grants.
//     -> grantCnt[0]=0xFFFF, holding (saturation).

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_pkg : shared types for the data-memory port arbiter     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_arbiter_pkg;

  localparam int DATA_W          = 32;
  localparam int DATA_ADDR_W     = 32;
  localparam int DATA_MEM_OFFSET = 2;
  localparam int DMEM_MAX_PORTS  = 4;

  typedef logic [DATA_W-1:0]                 DataPath;
  typedef logic [DATA_ADDR_W-1:0]            DataAddrPath;
  // Sized for the largest legal port count so one type serves every build.
  typedef logic [$clog2(DMEM_MAX_PORTS)-1:0] DmemPortIdx;

  typedef struct packed {
    logic        write;
    DataAddrPath addr;
    DataPath     data;
  } DmemReq;

  typedef struct packed {
    logic    valid;
    logic    write;
    logic    err;
    DataPath data;
  } DmemRsp;

  function automatic logic is_aligned(input logic [DATA_MEM_OFFSET-1:0] lsbs);
    return lsbs == '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0]         reqVec,
  input  logic [$clog2(NUM_PORTS)-1:0] ptr,
  output logic [NUM_PORTS-1:0]         grant,
  output logic [$clog2(NUM_PORTS)-1:0] win,
  output logic                         anyGrant
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  function automatic logic [PORT_W-1:0] wrap_idx(input logic [PORT_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PORT_W'(s);
  endfunction

  always_comb begin
    grant    = '0;
    win      = '0;
    anyGrant = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!anyGrant && reqVec[wrap_idx(ptr, i)]) begin
        anyGrant               = 1'b1;
        win                    = wrap_idx(ptr, i);
        grant[wrap_idx(ptr, i)] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter : round-robin sharing of the single-port data memory    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_PORTS-1:0]                reqValid,
  output logic [NUM_PORTS-1:0]                reqReady,
  input  logic [NUM_PORTS-1:0]                reqWrite,
  input  logic [NUM_PORTS-1:0][DATA_ADDR_W-1:0] reqAddr,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    reqData,
  output logic [NUM_PORTS-1:0]                rspValid,
  output logic                                rspWrite,
  output logic                                rspErr,
  output logic [DATA_W-1:0]                   rspData,
  output logic [DATA_ADDR_W-1:0]              memAddr,
  output logic [DATA_W-1:0]                   memDataIn,
  output logic                                memWrEnable,
  input  logic [DATA_W-1:0]                   memDataOut,
  output logic [NUM_PORTS-1:0][CNT_W-1:0]     grantCnt
);

  localparam int PORT_W = $clog2(NUM_PORTS);

  logic [PORT_W-1:0]    rr_ptr;
  logic [PORT_W-1:0]    next_ptr;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    win;
  logic                 any_grant;
  logic                 accept;
  logic                 aligned;
  logic                 fwd;
  DmemReq               sel_req;
  DmemRsp               rsp;

  logic                 rsp_valid;
  DmemPortIdx           rsp_port;
  logic                 rsp_write;
  logic                 rsp_err;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .reqVec   (reqValid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .win      (win),
    .anyGrant (any_grant)
  );

  // Nothing is granted while reset is held, so requesters never see a stale ready.
  assign accept  = any_grant & rst;
  assign sel_req = '{write: reqWrite[win], addr: reqAddr[win], data: reqData[win]};
  assign aligned = is_aligned(sel_req.addr[DATA_MEM_OFFSET-1:0]);
  assign fwd     = accept & aligned;

  assign reqReady    = accept ? grant : '0;
  assign memAddr     = fwd ? sel_req.addr : '0;
  assign memDataIn   = fwd ? sel_req.data : '0;
  assign memWrEnable = fwd & sel_req.write;

  always_comb begin
    if (win == PORT_W'(NUM_PORTS - 1)) next_ptr = '0;
    else                               next_ptr = win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_port  <= '0;
      rsp_write <= 1'b0;
      rsp_err   <= 1'b0;
      grantCnt  <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_port  <= DmemPortIdx'(win);
      rsp_write <= sel_req.write;
      rsp_err   <= !aligned;
      if (accept) begin
        rr_ptr <= next_ptr;
        if (grantCnt[win] != '1) grantCnt[win] <= grantCnt[win] + 1'b1;
      end
    end
  end

  // DMem's registered read address lines its output up with the response cycle.
  always_comb begin
    rsp.valid = rsp_valid & rst;
    rsp.write = rsp.valid & rsp_write;
    rsp.err   = rsp.valid & rsp_err;
    rsp.data  = (rsp.valid && !rsp_write && !rsp_err) ? memDataOut : '0;
  end

  always_comb begin
    rspValid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      rspValid[p] = rsp.valid && (rsp_port == DmemPortIdx'(p));
    end
  end

  assign rspWrite = rsp.write;
  assign rspErr   = rsp.err;
  assign rspData  = rsp.data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter : directed self-checking bench with a DMem model     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        reqValid, reqReady, reqWrite, rspValid;
  logic [1:0][31:0]  reqAddr, reqData;
  logic              rspWrite, rspErr, memWrEnable;
  logic [31:0]       rspData, memAddr, memDataIn, memDataOut;
  logic [1:0][15:0]  grantCnt;

  // Second instance with a 2-bit counter to reach the saturation boundary quickly.
  logic [1:0]        s_reqValid, s_reqReady, s_rspValid;
  logic              s_rspWrite, s_rspErr, s_memWrEnable;
  logic [31:0]       s_rspData, s_memAddr, s_memDataIn;
  logic [31:0]       s_memDataOut = 32'h0;
  logic [1:0]        s_reqWrite = 2'b00;
  logic [1:0][31:0]  s_reqAddr = '0, s_reqData = '0;
  logic [1:0][1:0]   s_grantCnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [5:0]  mem_raddr;

  always #5 clk = ~clk;

  // Single-port DMem: write commits and read address registers on the same edge.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (memWrEnable) begin
      mem[memAddr[7:2]] <= memDataIn;
    end
    mem_raddr <= memAddr[7:2];
  end
  assign memDataOut = mem[mem_raddr];

  dmem_arbiter #(.NUM_PORTS(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqData(reqData),
    .rspValid(rspValid), .rspWrite(rspWrite), .rspErr(rspErr), .rspData(rspData),
    .memAddr(memAddr), .memDataIn(memDataIn), .memWrEnable(memWrEnable),
    .memDataOut(memDataOut), .grantCnt(grantCnt)
  );

  dmem_arbiter #(.NUM_PORTS(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .reqValid(s_reqValid), .reqReady(s_reqReady),
    .reqWrite(s_reqWrite), .reqAddr(s_reqAddr), .reqData(s_reqData),
    .rspValid(s_rspValid), .rspWrite(s_rspWrite), .rspErr(s_rspErr), .rspData(s_rspData),
    .memAddr(s_memAddr), .memDataIn(s_memDataIn), .memWrEnable(s_memWrEnable),
    .memDataOut(s_memDataOut), .grantCnt(s_grantCnt)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; reqValid = 2'b11; reqWrite = 2'b00;
    reqAddr = '0; reqData = '0; s_reqValid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (reqReady !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", reqReady); end
      checks++; if (memWrEnable !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", memWrEnable); end
      checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL reset_rspvalid: got %b expected 00", rspValid); end
      if (c > 0) begin
        checks++; if (grantCnt !== '0) begin errors++; $display("FAIL reset_grantcnt: got %h expected 0", grantCnt); end
        checks++; if (s_grantCnt !== '0) begin errors++; $display("FAIL reset_sat_grantcnt: got %h expected 0", s_grantCnt); end
      end
    end
    next_cycle();
  endtask

  task automatic test_write_then_read();
    rst = 1'b1; reqValid = 2'b01; reqWrite = 2'b01;
    reqAddr[0] = 32'h10; reqData[0] = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL wr_ready: got %b expected 01", reqReady); end
    checks++; if (memWrEnable !== 1'b1) begin errors++; $display("FAIL wr_wren: got %b expected 1", memWrEnable); end
    checks++; if (memAddr !== 32'h10) begin errors++; $display("FAIL wr_addr: got %h expected 00000010", memAddr); end
    checks++; if (memDataIn !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h expected deadbeef", memDataIn); end
    next_cycle();
    reqWrite = 2'b00;
    @(negedge clk);
    checks++; if (rspValid !== 2'b01) begin errors++; $display("FAIL wr_rspvalid: got %b expected 01", rspValid); end
    checks++; if (rspWrite !== 1'b1) begin errors++; $display("FAIL wr_rspwrite: got %b expected 1", rspWrite); end
    checks++; if (rspData !== 32'h0) begin errors++; $display("FAIL wr_rspdata: got %h expected 0", rspData); end
    next_cycle();
    reqValid = 2'b00;
    @(negedge clk);
    checks++; if (rspValid !== 2'b01) begin errors++; $display("FAIL rd_rspvalid: got %b expected 01", rspValid); end
    checks++; if (rspWrite !== 1'b0) begin errors++; $display("FAIL rd_rspwrite: got %b expected 0", rspWrite); end
    checks++; if (rspData !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rspdata: got %h expected deadbeef", rspData); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    rst = 1'b0; reqValid = 2'b11; reqWrite = 2'b00;
    reqAddr[0] = 32'h0; reqAddr[1] = 32'h4;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (reqReady !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, reqReady, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      next_cycle();
    end
    reqValid = 2'b00;
    @(negedge clk);
    checks++; if (grantCnt[0] !== 16'd3) begin errors++; $display("FAIL rr_cnt0: got %0d expected 3", grantCnt[0]); end
    checks++; if (grantCnt[1] !== 16'd3) begin errors++; $display("FAIL rr_cnt1: got %0d expected 3", grantCnt[1]); end
    next_cycle();
  endtask

  task automatic test_misaligned();
    reqValid = 2'b10; reqWrite = 2'b00; reqAddr[1] = 32'h13;
    @(negedge clk);
    checks++; if (reqReady !== 2'b10) begin errors++; $display("FAIL mis_ready: got %b expected 10", reqReady); end
    checks++; if (memWrEnable !== 1'b0) begin errors++; $display("FAIL mis_wren: got %b expected 0", memWrEnable); end
    next_cycle();
    reqValid = 2'b00;
    @(negedge clk);
    checks++; if (rspValid !== 2'b10) begin errors++; $display("FAIL mis_rspvalid: got %b expected 10", rspValid); end
    checks++; if (rspErr !== 1'b1) begin errors++; $display("FAIL mis_rsperr: got %b expected 1", rspErr); end
    checks++; if (rspData !== 32'h0) begin errors++; $display("FAIL mis_rspdata: got %h expected 0", rspData); end
    checks++; if (grantCnt[1] !== 16'd4) begin errors++; $display("FAIL mis_cnt1: got %0d expected 4", grantCnt[1]); end
    next_cycle();
  endtask

  task automatic test_reset_pending();
    reqValid = 2'b10; reqWrite = 2'b10;
    reqAddr[1] = 32'h20; reqData[1] = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (reqReady !== 2'b10) begin errors++; $display("FAIL rp_ready: got %b expected 10", reqReady); end
    next_cycle();
    rst = 1'b0; reqValid = 2'b00; reqWrite = 2'b00;
    @(negedge clk);
    checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL rp_rsp_in_reset: got %b expected 00", rspValid); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rspValid !== 2'b00) begin errors++; $display("FAIL rp_rsp_after: got %b expected 00", rspValid); end
    next_cycle();
    reqValid = 2'b11; reqAddr[0] = 32'h20; reqAddr[1] = 32'h24;
    @(negedge clk);
    checks++; if (reqReady !== 2'b01) begin errors++; $display("FAIL rp_ptr_reset: got %b expected 01", reqReady); end
    next_cycle();
    reqValid = 2'b00;
    @(negedge clk);
    checks++; if (rspValid !== 2'b01) begin errors++; $display("FAIL rp_read_valid: got %b expected 01", rspValid); end
    checks++;
    if ($isunknown(rspData) || (rspData !== 32'hCAFEF00D && rspData !== 32'h1000_0008)) begin
      errors++; $display("FAIL rp_read_data: got %h expected cafef00d or 10000008", rspData);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    s_reqValid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if (s_grantCnt[0] !== ((i < 2) ? 2'(i + 1) : 2'd3)) begin
        errors++; $display("FAIL sat_cnt0[%0d]: got %0d expected %0d", i, s_grantCnt[0], (i < 2) ? i + 1 : 3);
      end
    end
    s_reqValid = 2'b00;
    checks++; if (s_grantCnt[1] !== 2'd0) begin errors++; $display("FAIL sat_cnt1: got %0d expected 0", s_grantCnt[1]); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_round_robin();
    test_misaligned();
    test_reset_pending();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
